// File: rtl/ysyx_24080006_imem_rsp.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_imem_rsp
//
// AXI4 read-channel responder (AR/R only) for instruction fetch and icache
// line fills. It serves reads from a word-addressed synchronous memory whose
// read data appears the cycle after the strobe. It supports FIXED, INCR and
// WRAP bursts, a fixed extra start latency, and DECERR/SLVERR responses.
// An errored burst still returns every beat, with zero data.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   r_m2s      : AR channel request fields plus rready
//   r_s2m      : arready plus R channel response fields
//   mem_req    : memory read strobe
//   mem_addr   : word index into the memory window
//   mem_rdata  : memory read data, valid the cycle after mem_req
// ---------------------------------------------------------------------------

package ysyx_24080006_axi_pkg;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
  } axi_r_s2m_t;

endpackage

module ysyx_24080006_imem_rsp
  import ysyx_24080006_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  axi_r_m2s_t                     r_m2s,
  output axi_r_s2m_t                     r_s2m,
  output logic                           mem_req,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
  input  logic [31:0]                    mem_rdata
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, DELAY, READ, RESP} state_t;

  state_t        state;
  state_t        state_n;
  logic          arready_q;
  logic          first_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_n;
  logic [3:0]    id_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_q;
  logic [1:0]    burst_q;
  logic [1:0]    err_q;
  logic [3:0]    cnt_q;
  logic [31:0]   rdata_q;

  logic [31:0]   offset;
  logic          in_win;
  logic [1:0]    err_c;
  logic          ar_hs;
  logic          r_hs;
  logic          last;
  logic [AW-1:0] wrap_mask;
  logic [31:0]   beat_data;

  // Window check uses a 33-bit compare so a window ending at 4 GiB still works.
  assign offset = r_m2s.araddr - BASE_ADDR;
  assign in_win = (r_m2s.araddr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);

  // Error class is decided once at acceptance; an unmapped address wins over
  // an illegal burst shape.
  always_comb begin
    err_c = RESP_OKAY;
    if (!in_win) begin
      err_c = RESP_DECERR;
    end else if ((r_m2s.arburst == BURST_RSVD) || (r_m2s.arsize > 3'd2) ||
                 ((r_m2s.arburst == BURST_WRAP) &&
                  !((r_m2s.arlen == 8'd1) || (r_m2s.arlen == 8'd3) ||
                    (r_m2s.arlen == 8'd7) || (r_m2s.arlen == 8'd15)))) begin
      err_c = RESP_SLVERR;
    end
  end

  // arready_q is only ever high in IDLE, so it alone qualifies the AR handshake.
  assign ar_hs     = arready_q & r_m2s.arvalid;
  assign r_hs      = (state == RESP) & r_m2s.rready;
  assign last      = (beat_q == len_q);
  assign beat_data = (err_q == RESP_OKAY) ? mem_rdata : 32'd0;

  // WRAP lengths are 2/4/8/16 beats, so arlen doubles as the in-block index
  // mask; the upper index bits stay put and the low bits roll over.
  assign wrap_mask = AW'(len_q);

  always_comb begin
    idx_n = idx_q + AW'(1);
    case (burst_q)
      BURST_FIXED: idx_n = idx_q;
      BURST_WRAP:  idx_n = (idx_q & ~wrap_mask) | ((idx_q + AW'(1)) & wrap_mask);
      default:     ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          state_n = (LATENCY > 0) ? DELAY : READ;
        end
      end
      DELAY: begin
        if (cnt_q == 4'd0) begin
          state_n = READ;
        end
      end
      READ: begin
        state_n = RESP;
      end
      RESP: begin
        if (r_hs) begin
          state_n = last ? IDLE : READ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // arready is registered from the next state so it stays low throughout
  // reset and rises on the first edge afterwards. first_q marks the first
  // RESP cycle, when the memory output is live and gets captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state     <= state_n;
      arready_q <= (state_n == IDLE);
      first_q   <= (state == READ);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      id_q    <= 4'd0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      burst_q <= 2'b00;
      err_q   <= RESP_OKAY;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      if (ar_hs) begin
        idx_q   <= offset[AW+1:2];
        id_q    <= r_m2s.arid;
        len_q   <= r_m2s.arlen;
        burst_q <= r_m2s.arburst;
        err_q   <= err_c;
        beat_q  <= 8'd0;
        cnt_q   <= LAT_LOAD;
      end else if (r_hs && !last) begin
        idx_q  <= idx_n;
        beat_q <= beat_q + 8'd1;
      end
      if ((state == DELAY) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (first_q) begin
        rdata_q <= beat_data;
      end
    end
  end

  // In the first RESP cycle the data comes straight from memory; afterwards
  // the captured copy keeps it stable while the master stalls.
  always_comb begin
    r_s2m         = '0;
    r_s2m.arready = arready_q;
    if (state == RESP) begin
      r_s2m.rvalid = 1'b1;
      r_s2m.rdata  = first_q ? beat_data : rdata_q;
      r_s2m.rresp  = err_q;
      r_s2m.rlast  = last;
      r_s2m.rid    = id_q;
    end
  end

  assign mem_req  = (state == READ) && (err_q == RESP_OKAY);
  assign mem_addr = mem_req ? idx_q : '0;

endmodule

// File: tb/tb_ysyx_24080006_imem_rsp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24080006_imem_rsp
//
// Self-checking bench for the instruction-memory read responder. Two
// responders share a memory image: one with no start latency and one with
// three cycles. A select signal routes the AR/R traffic to one of them.
// Directed vectors come from a table. Random bursts are checked against a
// reference model that computes beat addresses, data and responses
// arithmetically. A hand-written sequence covers reset in the middle of a
// burst.
// ---------------------------------------------------------------------------

module tb_ysyx_24080006_imem_rsp;
  import ysyx_24080006_axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4096;
  localparam int          AW    = 12;
  localparam logic [31:0] WIN   = 32'(4 * DEPTH);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  axi_r_m2s_t    m2s;
  axi_r_m2s_t    m2s0;
  axi_r_m2s_t    m2s3;
  axi_r_s2m_t    s2m;
  axi_r_s2m_t    s2m0;
  axi_r_s2m_t    s2m3;
  logic          sel;
  logic          mreq0;
  logic          mreq3;
  logic          mreq;
  logic [AW-1:0] maddr0;
  logic [AW-1:0] maddr3;
  logic [AW-1:0] maddr;
  logic [31:0]   rd0;
  logic [31:0]   rd3;
  logic [31:0]   mem [DEPTH];

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int memQ[$];
  int memCyc[$];
  logic [1:0]  firstResp;
  logic [31:0] firstData;

  ysyx_24080006_imem_rsp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .r_m2s(m2s0), .r_s2m(s2m0),
    .mem_req(mreq0), .mem_addr(maddr0), .mem_rdata(rd0)
  );

  ysyx_24080006_imem_rsp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .r_m2s(m2s3), .r_s2m(s2m3),
    .mem_req(mreq3), .mem_addr(maddr3), .mem_rdata(rd3)
  );

  // Route the master to the selected responder; the other sees an idle bus.
  always_comb begin
    m2s0 = '0;
    m2s3 = '0;
    if (sel) m2s3 = m2s;
    else     m2s0 = m2s;
    s2m = sel ? s2m3 : s2m0;
  end
  assign mreq  = sel ? mreq3 : mreq0;
  assign maddr = sel ? maddr3 : maddr0;

  // Synchronous memories: data is valid the cycle after the strobe.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mreq0) rd0 <= mem[maddr0];
    if (mreq3) rd3 <= mem[maddr3];
  end

  // Record every memory read the selected responder issues.
  always @(negedge clock) begin
    if (mreq) begin
      memQ.push_back(int'(maddr));
      memCyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the response class of a whole burst.
  function automatic logic [1:0] modelErr(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    longint a;
    a = {32'd0, addr};
    if (a < {32'd0, BASE} || a >= {32'd0, BASE} + {32'd0, WIN}) return 2'b11;
    if (burst == 2'b11 || size > 3'd2) return 2'b10;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
    return 2'b00;
  endfunction

  // Reference model: the word index of beat k of an in-window burst.
  function automatic int modelIdx(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst, input int k);
    int w0;
    int blk;
    int start;
    w0    = int'((addr - BASE) >> 2);
    blk   = int'(len) + 1;
    start = (w0 / blk) * blk;
    case (burst)
      2'b00:   return w0;
      2'b10:   return start + (w0 - start + k) % blk;
      default: return (w0 + k) % DEPTH;
    endcase
  endfunction

  // Issue one burst and check every beat, the timing and the memory reads.
  task automatic applyStimulus(input int s, input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int stallBeat, input int stallLen);
    int          lat;
    int          t;
    int          hsCyc;
    int          nBeats;
    int          nExp;
    logic [1:0]  err;
    logic [31:0] expData;
    logic [31:0] holdData;
    lat    = (s != 0) ? 3 : 0;
    err    = modelErr(addr, len, size, burst);
    nBeats = int'(len) + 1;
    @(negedge clock);
    sel = (s != 0);
    memQ.delete();
    memCyc.delete();
    m2s.arvalid = 1'b1;
    m2s.araddr  = addr;
    m2s.arid    = id;
    m2s.arlen   = len;
    m2s.arsize  = size;
    m2s.arburst = burst;
    m2s.rready  = 1'b0;
    t = 0;
    while (!s2m.arready && t < 50) begin
      @(negedge clock);
      t++;
    end
    checkOutput("ar_accept", s2m.arready, 1);
    if (!s2m.arready) begin
      m2s.arvalid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    m2s.arvalid = 1'b0;
    hsCyc = cyc;
    @(negedge clock);
    checkOutput("arready_low_after_ar", s2m.arready, 0);
    for (int k = 0; k < nBeats; k++) begin
      t = 0;
      while (!s2m.rvalid && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (!s2m.rvalid) begin
        checkOutput("rvalid_timeout", 0, 1);
        break;
      end
      if (k == 0) checkOutput("first_rvalid_cycle", 64'(cyc - hsCyc), 64'(1 + lat));
      expData = (err != 2'b00) ? 32'd0 : mem[modelIdx(addr, len, burst, k)];
      checkOutput($sformatf("rdata[%0d]", k), s2m.rdata, expData);
      checkOutput($sformatf("rresp[%0d]", k), s2m.rresp, err);
      checkOutput($sformatf("rid[%0d]", k), s2m.rid, id);
      checkOutput($sformatf("rlast[%0d]", k), s2m.rlast, (k == int'(len)));
      checkOutput($sformatf("arready_busy[%0d]", k), s2m.arready, 0);
      if (k == 0) begin
        firstResp = s2m.rresp;
        firstData = s2m.rdata;
      end
      if (k == stallBeat) begin
        holdData = s2m.rdata;
        for (int j = 0; j < stallLen; j++) begin
          @(negedge clock);
          checkOutput("stall_rvalid", s2m.rvalid, 1);
          checkOutput("stall_rdata", s2m.rdata, holdData);
          checkOutput("stall_rlast", s2m.rlast, (k == int'(len)));
          checkOutput("stall_rresp", s2m.rresp, err);
        end
      end
      m2s.rready = 1'b1;
      @(posedge clock);
      #1;
      m2s.rready = 1'b0;
    end
    @(negedge clock);
    checkOutput("arready_after_last", s2m.arready, 1);
    nExp = (err != 2'b00) ? 0 : nBeats;
    checkOutput("mem_req_count", 64'(memQ.size()), 64'(nExp));
    for (int i = 0; i < nExp && i < memQ.size(); i++) begin
      checkOutput($sformatf("mem_addr[%0d]", i), 64'(memQ[i]), 64'(modelIdx(addr, len, burst, i)));
    end
    if (nExp > 0 && memCyc.size() > 0) checkOutput("mem_req_cycle", 64'(memCyc[0] - hsCyc), 64'(lat));
  endtask

  typedef struct packed {
    int               s;
    logic [31:0]      addr;
    logic [3:0]       id;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    int               stallBeat;
    int               stallLen;
    logic [1:0]       resp;
    int               nSeq;
    logic [3:0][11:0] seq;
    bit               chkD0;
    logic [31:0]      d0;
  } vec_t;

  function automatic vec_t mk(input int s, input logic [31:0] addr, input logic [3:0] id,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input int sb, input int sl, input logic [1:0] resp, input int nSeq,
                              input int e0, input int e1, input int e2, input int e3,
                              input bit chk, input logic [31:0] d0);
    vec_t v;
    v.s = s; v.addr = addr; v.id = id; v.len = len; v.size = size; v.burst = burst;
    v.stallBeat = sb; v.stallLen = sl; v.resp = resp; v.nSeq = nSeq;
    v.seq[0] = 12'(e0); v.seq[1] = 12'(e1); v.seq[2] = 12'(e2); v.seq[3] = 12'(e3);
    v.chkD0 = chk; v.d0 = d0;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    int          hs;
    int          t;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          r;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD_BEEF;
    m2s = '0;
    sel = 1'b0;

    // Reset values while reset is held low.
    #12;
    checkOutput("rst_arready", s2m0.arready, 0);
    checkOutput("rst_rvalid", s2m0.rvalid, 0);
    checkOutput("rst_rlast", s2m0.rlast, 0);
    checkOutput("rst_rresp", s2m0.rresp, 0);
    checkOutput("rst_rdata", s2m0.rdata, 0);
    checkOutput("rst_rid", s2m0.rid, 0);
    checkOutput("rst_mem_req", mreq0, 0);
    checkOutput("rst_mem_addr", maddr0, 0);
    checkOutput("rst_arready3", s2m3.arready, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("arready_before_edge", s2m0.arready, 0);
    @(negedge clock);
    checkOutput("arready_first_edge", s2m0.arready, 1);
    checkOutput("arready_first_edge3", s2m3.arready, 1);

    // s, addr, id, len, size, burst, stallBeat, stallLen, resp, nSeq, seq0..3, chkD0, d0
    vecs.push_back(mk(0, BASE + 32'h14, 4'd3, 8'd0, 3'd2, 2'b01, -1, 0, 2'b00, 1, 5, 0, 0, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, BASE + 32'h40, 4'd1, 8'd3, 3'd2, 2'b01, 1, 3, 2'b00, 4, 16, 17, 18, 19, 0, 32'd0));
    vecs.push_back(mk(0, BASE + 32'h48, 4'd2, 8'd3, 3'd2, 2'b10, -1, 0, 2'b00, 4, 18, 19, 16, 17, 0, 32'd0));
    vecs.push_back(mk(0, BASE + WIN, 4'd4, 8'd1, 3'd2, 2'b01, 0, 2, 2'b11, 0, 0, 0, 0, 0, 1, 32'd0));
    vecs.push_back(mk(0, BASE + 32'h20, 4'd5, 8'd0, 3'd3, 2'b01, -1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 32'd0));
    vecs.push_back(mk(0, BASE + 32'h20, 4'd6, 8'd1, 3'd2, 2'b11, -1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 32'd0));
    vecs.push_back(mk(0, BASE + 32'h20, 4'd7, 8'd2, 3'd2, 2'b10, -1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 32'd0));
    vecs.push_back(mk(0, BASE - 32'd4, 4'd8, 8'd0, 3'd2, 2'b01, -1, 0, 2'b11, 0, 0, 0, 0, 0, 1, 32'd0));
    vecs.push_back(mk(0, BASE + WIN, 4'd15, 8'd0, 3'd3, 2'b01, -1, 0, 2'b11, 0, 0, 0, 0, 0, 1, 32'd0));
    vecs.push_back(mk(0, BASE + WIN - 32'd4, 4'd9, 8'd0, 3'd2, 2'b00, -1, 0, 2'b00, 1, 4095, 0, 0, 0, 0, 32'd0));
    vecs.push_back(mk(0, BASE + 32'h8, 4'd10, 8'd2, 3'd2, 2'b00, -1, 0, 2'b00, 3, 2, 2, 2, 0, 0, 32'd0));
    vecs.push_back(mk(0, BASE + WIN - 32'd8, 4'd11, 8'd255, 3'd2, 2'b01, 100, 2, 2'b00, 4, 4094, 4095, 0, 1, 0, 32'd0));
    vecs.push_back(mk(1, BASE + 32'h14, 4'd12, 8'd1, 3'd2, 2'b01, 0, 2, 2'b00, 2, 5, 6, 0, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, BASE + 32'h5C, 4'd13, 8'd7, 3'd2, 2'b10, -1, 0, 2'b00, 4, 23, 16, 17, 18, 0, 32'd0));
    vecs.push_back(mk(0, BASE + 32'h17, 4'd14, 8'd0, 3'd0, 2'b01, -1, 0, 2'b00, 1, 5, 0, 0, 0, 1, 32'hDEAD_BEEF));

    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.s, v.addr, v.id, v.len, v.size, v.burst, v.stallBeat, v.stallLen);
      checkOutput($sformatf("tbl%0d_resp", i), firstResp, v.resp);
      for (int j = 0; j < v.nSeq && j < memQ.size(); j++) begin
        checkOutput($sformatf("tbl%0d_addr%0d", i, j), 64'(memQ[j]), 64'(v.seq[j]));
      end
      if (v.chkD0) checkOutput($sformatf("tbl%0d_data", i), firstData, v.d0);
    end

    // Random bursts against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (r == 7) addr = BASE + WIN + 32'($urandom_range(0, 255));
      else if (r == 8) addr = BASE - 32'd1 - 32'($urandom_range(0, 255));
      else             addr = $urandom;
      len  = 8'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      applyStimulus(int'($urandom_range(0, 1)), addr, 4'($urandom), len, size,
                    2'($urandom_range(0, 3)), int'($urandom_range(0, int'(len))),
                    int'($urandom_range(0, 3)));
    end

    // Reset in the middle of an 8-beat burst, with rready tied high.
    @(negedge clock);
    sel = 1'b0;
    m2s.arvalid = 1'b1;
    m2s.araddr  = BASE + 32'h100;
    m2s.arid    = 4'd9;
    m2s.arlen   = 8'd7;
    m2s.arsize  = 3'd2;
    m2s.arburst = 2'b01;
    t = 0;
    while (!s2m.arready && t < 50) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    m2s.arvalid = 1'b0;
    m2s.rready  = 1'b1;
    hs = 0;
    t  = 0;
    while (t < 100) begin
      @(negedge clock);
      t++;
      if (s2m.rvalid) begin
        if (hs == 2) break;
        hs++;
      end
    end
    checkOutput("rst_mid_rvalid_before", s2m.rvalid, 1);
    #2;
    reset = 1'b0;
    m2s.rready = 1'b0;
    #1;
    checkOutput("rst_mid_rvalid", s2m.rvalid, 0);
    checkOutput("rst_mid_rlast", s2m.rlast, 0);
    checkOutput("rst_mid_rdata", s2m.rdata, 0);
    checkOutput("rst_mid_mem_req", mreq, 0);
    checkOutput("rst_mid_arready", s2m.arready, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_rel_arready_pre", s2m.arready, 0);
    @(negedge clock);
    checkOutput("rst_rel_arready", s2m.arready, 1);
    checkOutput("rst_rel_rvalid", s2m.rvalid, 0);
    applyStimulus(0, BASE + 32'h14, 4'd3, 8'd0, 3'd2, 2'b01, -1, 0);
    checkOutput("rst_fresh_data", firstData, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_imem_rsp.md
# ysyx_24080006_imem_rsp

AXI4 read-channel responder (AR/R only) that serves instruction-fetch and icache line-fill reads from a word-addressed synchronous memory. It sits on the slave side of the IFU/ICU fetch port, answering `axi_r_m2s_t` requests with `axi_r_s2m_t` responses. It supports single-beat and burst reads, a programmable initial latency, and error responses for unmapped or illegal requests.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: byte base address of the mapped window.
- `DEPTH_WORDS`, default 4096: window size in 32-bit words; must be a power of two.
- `LATENCY`, default 0: extra idle cycles between AR acceptance and the first memory read (0..15).
- `clock`  input  1: single clock; all state is updated on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `r_m2s`  input  `axi_r_m2s_t`: fields used are `arvalid`, `araddr[31:0]`, `arid[3:0]`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]` and `rready`.
- `r_s2m`  output  `axi_r_s2m_t`: fields driven are `arready`, `rvalid`, `rdata[31:0]`, `rresp[1:0]`, `rlast` and `rid[3:0]`.
- `mem_req`  output  1: memory read strobe.
- `mem_addr`  output  $clog2(DEPTH_WORDS): word index into the memory.
- `mem_rdata`  input  32: read data, valid the cycle after `mem_req`.

## Operation
- States are IDLE, DELAY, READ, RESP.
- **IDLE**
  - `arready`=1.
  - On `arvalid&arready`, latch `araddr`, `arid`, `arlen`, `arburst` and `arsize`, clear the beat counter, and compute `err`.
  - Go to DELAY if `LATENCY`>0, else READ.
- **DELAY**
  - `arready`=0.
  - A counter loads `LATENCY-1` and counts down.
  - Go to READ at 0.
- **READ**
  - If `err`==OKAY, assert `mem_req` with `mem_addr`=`(addr-BASE_ADDR)>>2`.
  - Go to RESP.
- **RESP**
  - `rvalid`=1. `rdata`=`mem_rdata`, registered on entry (0 on error).
  - `rresp`=`err`, `rid`=latched id, `rlast`=(beat==`arlen`).
  - All R outputs are held stable while `rready`=0.
  - On handshake with `rlast`: go to IDLE.
  - On handshake without `rlast`: advance the address, beat+1, go to READ.
- Error classification is per burst, fixed at AR acceptance, and applied to every beat:
  - `araddr` outside [`BASE_ADDR`, `BASE_ADDR`+4·`DEPTH_WORDS`) → DECERR (2'b11).
  - `arburst`==2'b11, `arsize`>2, or WRAP with `arlen`∉{1,3,7,15} → SLVERR (2'b10).
  - Otherwise → OKAY (2'b00).
- On any error, `mem_req` is never asserted, but exactly `arlen`+1 beats are still returned.
- Address advance (word granularity; `araddr[1:0]` ignored, the full word is always returned):
  - FIXED: unchanged.
  - INCR: +4. Carry above `BASE_ADDR` is not checked after acceptance; the in-window index wraps modulo `DEPTH_WORDS`.
  - WRAP: +4 within an aligned (`arlen`+1)·4 byte block; the low bits wrap to the block start.
- Beat counter is 8 bits. `arlen`=255 yields 256 beats; `rlast` is asserted only on beat 255.

## Timing
- Reset values, held asynchronously while `reset`=0:
  - `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0, `rid`=0.
  - `mem_req`=0, `mem_addr`=0, state IDLE.
- `arready` goes to 1 at the first rising edge after reset deassertion.
- AR handshake at edge N:
  - `mem_req` is high in cycle N+1+`LATENCY`.
  - First `rvalid` is high in cycle N+2+`LATENCY`.
- Burst throughput is 2 cycles per beat with `rready` tied high (READ then RESP).
- `arready` is low from the cycle after AR acceptance until the cycle after the last R handshake. Only one outstanding transaction; no AR/R overlap.
- Reset asserted mid-burst aborts the transaction immediately. No further beats are issued; the master must reissue.
- `arvalid` arriving while not in IDLE is ignored until IDLE; the responder never drops a latched request.

## Test plan
- **Single read, LATENCY=0:** memory word 5 = 32'hDEAD_BEEF; AR `araddr`=`BASE_ADDR`+0x14, `arlen`=0, `arid`=3 at edge N → `mem_req` in cycle N+1 with `mem_addr`=5; `rvalid` in cycle N+2 with `rdata`=32'hDEAD_BEEF, `rresp`=0, `rlast`=1, `rid`=3.
- **INCR 4-beat with backpressure:** `araddr`=`BASE_ADDR`+0x40, `arlen`=3, `rready` low for 3 cycles on beat 1 → `mem_addr` sequence 16,17,18,19; beat-1 `rdata` stable throughout the stall; `rlast` only on beat 3.
- **WRAP 4-beat:** `araddr`=`BASE_ADDR`+0x48, `arlen`=3, `arburst`=WRAP → `mem_addr` sequence 18,19,16,17.
- **Unmapped address:** `araddr`=`BASE_ADDR`+4·`DEPTH_WORDS`, `arlen`=1 → two beats with `rresp`=2'b11 and `rdata`=0; `mem_req` never asserted. `arsize`=3 request → `rresp`=2'b10.
- **LATENCY=3:** AR at edge N → `rvalid` first high in cycle N+5; `arready` low from N+1 until the last handshake.
- **Async reset mid-burst:** drop `reset` between edges during beat 2 of `arlen`=7 → `rvalid`/`mem_req` go to 0 immediately without a clock edge; after release, `arready`=1 at the next edge and a fresh single read returns correct data.
